// File: rtl/pipelined_shifter_if.sv
// Request/result handshake bundle for pipelined_shifter.
// master drives requests and accepts results; slave is the shifter itself.
interface pipelined_shifter_if #(
    parameter int N = 32
);
    localparam int SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] shamt;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    modport master (
        output in_valid, in_data, shamt, op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, shamt, op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR): stage k resolves shamt bit k,
// so a result leaves $clog2(N) cycles after acceptance; one global stall enable.
module pipelined_shifter #(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_shifter_if.slave bus
);
    localparam int L = $clog2(N);

    logic          en_s;
    logic          accept_s;
    logic          valid_r   [L];
    logic [N-1:0]  data_r    [L];
    logic [L-1:0]  shamt_r   [L];
    logic [1:0]    op_r      [L];
    logic          sign_r    [L];
    logic [N-1:0]  next_data_s [L];

    // One conditional shift by s; SRA fill uses the sign captured at acceptance.
    function automatic logic [N-1:0] shift_step(
        input logic [N-1:0] d,
        input int           s,
        input logic         do_shift,
        input logic [1:0]   op,
        input logic         sign
    );
        logic [N-1:0] r;
        if (do_shift) begin
            case (op)
                2'b00:   r = d << s;
                2'b01:   r = d >> s;
                2'b10:   r = (d >> s) | ({N{sign}} << (N - s));
                2'b11:   r = (d >> s) | (d << (N - s));
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Global advance enable: the whole pipe moves only when the output slot frees up.
    always_comb begin
        en_s     = !bus.out_valid || bus.out_ready;
        accept_s = bus.in_valid && en_s;
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = valid_r[L-1];
    assign bus.out_data  = data_r[L-1];

    // Per-stage shift results; stage 0 works straight off the request operands.
    always_comb begin
        for (int k = 0; k < L; k++) begin
            if (k == 0) begin
                next_data_s[k] = shift_step(bus.in_data, 32'd1, bus.shamt[0],
                                            bus.op, bus.in_data[N-1]);
            end else begin
                next_data_s[k] = shift_step(data_r[k-1], 32'd1 << k, shamt_r[k-1][k],
                                            op_r[k-1], sign_r[k-1]);
            end
        end
    end

    // Stage registers: all advance together on en_s, a non-accept inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= {N{1'b0}};
                shamt_r[k] <= {L{1'b0}};
                op_r[k]    <= 2'b00;
                sign_r[k]  <= 1'b0;
            end
        end else if (en_s) begin
            valid_r[0] <= accept_s;
            data_r[0]  <= next_data_s[0];
            shamt_r[0] <= bus.shamt;
            op_r[0]    <= bus.op;
            sign_r[0]  <= bus.in_data[N-1];
            for (int k = 1; k < L; k++) begin
                valid_r[k] <= valid_r[k-1];
                data_r[k]  <= next_data_s[k];
                shamt_r[k] <= shamt_r[k-1];
                op_r[k]    <= op_r[k-1];
                sign_r[k]  <= sign_r[k-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (N=32): results, latency, stall hold and reset flush.
module tb_pipelined_shifter;
    localparam int N = 32;
    localparam int L = 5;

    typedef struct {
        logic [31:0] data;
        int          acc_cycle;
        int          stall_snap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_shifter_if #(.N(N)) bus ();
    pipelined_shifter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          stalls = 0;
    bit          head_seen = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic [1:0] o);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return $unsigned($signed(d) >>> sh);
            default: begin
                dd = {d, d} >> sh;
                return dd[31:0];
            end
        endcase
    endfunction

    // Drive one cycle's inputs, then score everything visible in that cycle.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] o, input logic ordy, output bit acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.shamt     = sh;
        bus.op        = o;
        bus.out_ready = ordy;
        #1;
        cycle++;
        if (prev_hold) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data", 64'(bus.out_data), 64'(prev_data));
        end
        check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || ordy));
        if (bus.out_valid && !head_seen) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                check("latency", 64'(cycle),
                      64'(sb[0].acc_cycle + L + (stalls - sb[0].stall_snap)));
            end
            head_seen = 1'b1;
        end
        if (bus.out_valid && ordy) begin
            if (sb.size() > 0) begin
                check("data", 64'(bus.out_data), 64'(sb[0].data));
                void'(sb.pop_front());
            end
            head_seen = 1'b0;
        end
        acc = v && bus.in_ready;
        if (acc) sb.push_back('{ref_shift(d, sh, o), cycle, stalls});
        prev_hold = bus.out_valid && !ordy;
        prev_data = bus.out_data;
        if (!bus.in_ready) stalls++;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] o);
        bit acc;
        int tries = 0;
        do begin
            step(1'b1, d, sh, o, 1'b1, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            step(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, acc);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        step(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, acc);
    endtask

    logic [31:0] vd [10] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                             32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                             32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [4:0]  vs [10] = '{5'd31, 5'd4, 5'd31, 5'd31, 5'd1, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [1:0]  vo [10] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11,
                             2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] vx [10] = '{32'hFFFF_FFFF, 32'h07FF_FFFF, 32'h0000_0001, 32'h8000_0000,
                             32'h8000_0000, 32'h7812_3456, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                             32'hDEAD_BEEF, 32'hDEAD_BEEF};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        int rel;
        int n_acc;
        int guard;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.shamt     = 5'd0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Spec vectors checked against hand-derived constants as well as the model.
        for (int i = 0; i < 10; i++) begin
            check("vec_model", 64'(ref_shift(vd[i], vs[i], vo[i])), 64'(vx[i]));
            send(vd[i], vs[i], vo[i]);
        end
        drain();

        // Back-to-back stream of 8, full rate.
        for (int i = 0; i < 8; i++) send(32'h0101_0101 * (i + 1), 5'(i * 3), 2'(i));
        drain();

        // Same stream with out_ready low for relative cycles 6..8.
        base  = cycle + 1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 8 && guard < 50) begin
            rel = cycle + 1 - base;
            step(1'b1, 32'h0101_0101 * (n_acc + 1), 5'(n_acc * 3), 2'(n_acc),
                 !(rel >= 6 && rel <= 8), acc);
            if (rel >= 6 && rel <= 8) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (acc) n_acc++;
            guard++;
        end
        check("stall_all_sent", 64'(n_acc), 64'd8);
        drain();

        // Reset with three operations in flight: they must never surface.
        for (int i = 0; i < 3; i++) send(32'hCAFE_0000 + i, 5'd2, 2'b01);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        head_seen = 1'b0;
        prev_hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, acc);
            check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        send(32'h0000_00F0, 5'd4, 2'b01);
        drain();

        // Random traffic with random back-pressure.
        n_acc = 0;
        guard = 0;
        while (n_acc < 10000 && guard < 40000) begin
            step(1'($urandom_range(0, 9) < 7), 32'($urandom), 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 7), acc);
            if (acc) n_acc++;
            guard++;
        end
        check("random_count", 64'(n_acc), 64'd10000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
